// File: rtl/simmem_release_scheduler_pkg.sv
// Shared types and derived widths for the simulated-memory release scheduler.
package simmem_pkg;

    localparam int unsigned DefIdWidth        = 4;
    localparam int unsigned DefNumSlots       = 8;
    localparam int unsigned DefDelayWidth     = 6;
    localparam int unsigned DefMaxOutstanding = 128;

    // Ceil-log2 that never yields a zero-width vector.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CreditWidth  = clog2_min1(DefMaxOutstanding + 1);
    localparam int unsigned SlotIdxWidth = clog2_min1(DefNumSlots);

    typedef struct packed {
        logic                     valid;
        logic [DefIdWidth-1:0]    id;
        logic [DefDelayWidth-1:0] cnt;
    } release_slot_t;

endpackage

// File: rtl/simmem_release_scheduler_if.sv
// Request / response-done / release bundle between the scheduler and its environment.
interface simmem_release_scheduler_if
    import simmem_pkg::*;
#(
    parameter int unsigned IDWidth    = DefIdWidth,
    parameter int unsigned DelayWidth = DefDelayWidth
);

    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [IDWidth-1:0]      req_id_i;
    logic [DelayWidth-1:0]   req_delay_i;
    logic                    rsp_done_i;
    logic [IDWidth-1:0]      rsp_id_i;
    logic [2**IDWidth-1:0]   release_en_o;

    modport master (
        output req_valid_i, req_id_i, req_delay_i, rsp_done_i, rsp_id_i,
        input  req_ready_o, release_en_o
    );

    modport slave (
        input  req_valid_i, req_id_i, req_delay_i, rsp_done_i, rsp_id_i,
        output req_ready_o, release_en_o
    );

endinterface

// File: rtl/simmem_release_scheduler_slot.sv
// One countdown delay slot: loads (id, delay), pulses expire_o on its final count.
module simmem_release_slot
    import simmem_pkg::*;
#(
    parameter int unsigned IDWidth    = DefIdWidth,
    parameter int unsigned DelayWidth = DefDelayWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [IDWidth-1:0]    id_i,
    input  logic [DelayWidth-1:0] delay_i,
    output logic                  valid_o,
    output logic [IDWidth-1:0]    id_o,
    output logic                  expire_o
);

    logic                  valid_q, valid_d;
    logic [IDWidth-1:0]    id_q, id_d;
    logic [DelayWidth-1:0] cnt_q, cnt_d;

    // Load only ever targets a free slot, so it never collides with expiry.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            valid_d = 1'b1;
            id_d    = id_i;
            cnt_d   = (delay_i == '0) ? DelayWidth'(1) : delay_i;
        end else if (valid_q) begin
            if (cnt_q == DelayWidth'(1)) begin
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q - DelayWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o  = valid_q;
    assign id_o     = id_q;
    assign expire_o = valid_q && (cnt_q == DelayWidth'(1));

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-ID release credit scheduler: delays accepted requests, then grants release
// enables to the response bank until each credit is consumed by a response.
module simmem_release_scheduler
    import simmem_pkg::*;
#(
    parameter int unsigned IDWidth        = DefIdWidth,
    parameter int unsigned NumSlots       = DefNumSlots,
    parameter int unsigned DelayWidth     = DefDelayWidth,
    parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    simmem_release_scheduler_if.slave  bus
);

    localparam int unsigned NumIds = 2**IDWidth;
    localparam int unsigned OutW   = clog2_min1(MaxOutstanding + 1);
    localparam int unsigned IdxW   = clog2_min1(NumSlots);

    logic [NumSlots-1:0] slot_valid;
    logic [NumSlots-1:0] slot_expire;
    logic [NumSlots-1:0] slot_load;
    logic [IDWidth-1:0]  slot_id [NumSlots];

    logic            any_free;
    logic [IdxW-1:0] free_idx;
    logic            accept;
    logic            done_ok;

    logic [OutW-1:0] credit_q [NumIds];
    logic [OutW-1:0] credit_d [NumIds];
    logic [OutW-1:0] exp_cnt  [NumIds];
    logic [OutW-1:0] outstanding_q, outstanding_d;

    // Scan high to low so the lowest free index wins.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int unsigned i = NumSlots; i > 0; i--) begin
            if (!slot_valid[i-1]) begin
                any_free = 1'b1;
                free_idx = IdxW'(i - 1);
            end
        end
    end

    assign bus.req_ready_o = any_free && (outstanding_q < OutW'(MaxOutstanding));
    assign accept          = bus.req_valid_i && bus.req_ready_o;

    always_comb begin
        slot_load = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            slot_load[i] = accept && (free_idx == IdxW'(i));
        end
    end

    for (genvar s = 0; s < NumSlots; s++) begin : g_slot
        simmem_release_slot #(
            .IDWidth    (IDWidth),
            .DelayWidth (DelayWidth)
        ) u_slot (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .load_i   (slot_load[s]),
            .id_i     (bus.req_id_i),
            .delay_i  (bus.req_delay_i),
            .valid_o  (slot_valid[s]),
            .id_o     (slot_id[s]),
            .expire_o (slot_expire[s])
        );
    end

    always_comb begin
        for (int unsigned i = 0; i < NumIds; i++) begin
            exp_cnt[i] = '0;
            for (int unsigned s = 0; s < NumSlots; s++) begin
                if (slot_expire[s] && (slot_id[s] == IDWidth'(i))) begin
                    exp_cnt[i] = exp_cnt[i] + OutW'(1);
                end
            end
        end
    end

    // A done against an ID with no credit is dropped entirely.
    assign done_ok = bus.rsp_done_i && (credit_q[bus.rsp_id_i] != '0);

    always_comb begin
        for (int unsigned i = 0; i < NumIds; i++) begin
            credit_d[i] = credit_q[i] + exp_cnt[i]
                        - OutW'(done_ok && (bus.rsp_id_i == IDWidth'(i)));
        end
        outstanding_d = outstanding_q + OutW'(accept) - OutW'(done_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                credit_q[i] <= '0;
            end
            outstanding_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                credit_q[i] <= credit_d[i];
            end
            outstanding_q <= outstanding_d;
        end
    end

    always_comb begin
        bus.release_en_o = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            bus.release_en_o[i] = (credit_q[i] != '0);
        end
    end

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed bench for simmem_release_scheduler with a queue-based reference model.
module tb_simmem_release_scheduler;
    import simmem_pkg::*;

    localparam int unsigned NumIds = 16;
    localparam int unsigned NSlots = 8;
    localparam int          MaxOut = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    simmem_release_scheduler_if #(.IDWidth(4), .DelayWidth(6)) bus ();
    simmem_release_scheduler_if #(.IDWidth(4), .DelayWidth(6)) bus4 ();

    simmem_release_scheduler #(
        .IDWidth(4), .NumSlots(8), .DelayWidth(6), .MaxOutstanding(128)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    simmem_release_scheduler #(
        .IDWidth(4), .NumSlots(8), .DelayWidth(6), .MaxOutstanding(4)
    ) dut4 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of pending requests with remaining edges, plus credit counts.
    release_slot_t pend[$];
    int            m_credit [NumIds];
    int            m_out;
    bit            m_ready;

    task automatic m_reset();
        pend.delete();
        for (int i = 0; i < NumIds; i++) m_credit[i] = 0;
        m_out   = 0;
        m_ready = 1'b1;
    endtask

    task automatic m_step();
        release_slot_t nq[$];
        release_slot_t s;
        bit acc;
        acc = bus.req_valid_i && m_ready;
        if (bus.rsp_done_i) begin
            if (m_credit[bus.rsp_id_i] > 0) begin
                m_credit[bus.rsp_id_i]--;
                m_out--;
            end else begin
                errors++;
                $display("FAIL protocol: rsp_done for id %0d without credit at %0t", bus.rsp_id_i, $time);
            end
        end
        foreach (pend[k]) begin
            if (pend[k].cnt == 6'd1) begin
                m_credit[pend[k].id]++;
            end else begin
                s = pend[k];
                s.cnt = s.cnt - 6'd1;
                nq.push_back(s);
            end
        end
        pend = nq;
        if (acc) begin
            s.valid = 1'b1;
            s.id    = bus.req_id_i;
            s.cnt   = (bus.req_delay_i == 6'd0) ? 6'd1 : bus.req_delay_i;
            pend.push_back(s);
            m_out++;
        end
        m_ready = (pend.size() < NSlots) && (m_out < MaxOut);
    endtask

    function automatic logic [15:0] m_en();
        logic [15:0] e;
        e = '0;
        for (int i = 0; i < NumIds; i++) e[i] = (m_credit[i] != 0);
        return e;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_release_en", 32'(bus.release_en_o), 32'(m_en()));
            check("model_req_ready", 32'(bus.req_ready_o), 32'(m_ready));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input logic v, input logic [3:0] id, input logic [5:0] d);
        bus.req_valid_i = v;
        bus.req_id_i    = id;
        bus.req_delay_i = d;
    endtask

    task automatic done(input logic v, input logic [3:0] id);
        bus.rsp_done_i = v;
        bus.rsp_id_i   = id;
    endtask

    task automatic drain();
        for (int id = 0; id < NumIds; id++) begin
            while (m_credit[id] > 0) begin
                done(1'b1, 4'(id));
                cyc(1);
            end
        end
        done(1'b0, 4'd0);
        cyc(1);
    endtask

    initial begin
        req(1'b0, 4'd0, 6'd0);
        done(1'b0, 4'd0);
        bus4.req_valid_i = 1'b0;
        bus4.req_id_i    = '0;
        bus4.req_delay_i = '0;
        bus4.rsp_done_i  = 1'b0;
        bus4.rsp_id_i    = '0;
        #1;
        check("reset_release_en", 32'(bus.release_en_o), 32'h0);
        check("reset_req_ready", 32'(bus.req_ready_o), 32'h1);
        cyc(2);
        rst_n = 1'b1;

        // Single request id=3 d=5: rises 5 edges after handshake, done drops it.
        req(1'b1, 4'd3, 6'd5);
        cyc(1);
        req(1'b0, 4'd0, 6'd0);
        cyc(4);
        check("t1_before_rise", 32'(bus.release_en_o), 32'h0);
        cyc(1);
        check("t1_rise", 32'(bus.release_en_o), 32'h0008);
        cyc(1);
        done(1'b1, 4'd3);
        cyc(1);
        done(1'b0, 4'd0);
        check("t1_fall", 32'(bus.release_en_o), 32'h0);

        // d=0 then d=1 on id=2: credit reaches 2, two dones needed.
        req(1'b1, 4'd2, 6'd0);
        cyc(1);
        req(1'b1, 4'd2, 6'd1);
        cyc(1);
        req(1'b0, 4'd0, 6'd0);
        check("t2_rise", 32'(bus.release_en_o), 32'h0004);
        cyc(1);
        done(1'b1, 4'd2);
        cyc(1);
        check("t2_after_one_done", 32'(bus.release_en_o), 32'h0004);
        cyc(1);
        done(1'b0, 4'd0);
        check("t2_after_two_done", 32'(bus.release_en_o), 32'h0);

        // Two id=6 slots expiring on the same edge add two credits.
        req(1'b1, 4'd6, 6'd3);
        cyc(1);
        req(1'b1, 4'd6, 6'd2);
        cyc(1);
        req(1'b0, 4'd0, 6'd0);
        cyc(1);
        check("t2b_before", 32'(bus.release_en_o), 32'h0);
        cyc(1);
        check("t2b_rise", 32'(bus.release_en_o), 32'h0040);
        done(1'b1, 4'd6);
        cyc(1);
        check("t2b_one_done", 32'(bus.release_en_o), 32'h0040);
        cyc(1);
        done(1'b0, 4'd0);
        check("t2b_two_done", 32'(bus.release_en_o), 32'h0);

        // Same-edge expiry and done on id=1 with credit 1.
        req(1'b1, 4'd1, 6'd1);
        cyc(1);
        req(1'b1, 4'd1, 6'd2);
        cyc(1);
        req(1'b0, 4'd0, 6'd0);
        check("t5_credit1", 32'(bus.release_en_o), 32'h0002);
        cyc(1);
        done(1'b1, 4'd1);
        cyc(1);
        check("t5_same_edge", 32'(bus.release_en_o), 32'h0002);
        cyc(1);
        done(1'b0, 4'd0);
        check("t5_drained", 32'(bus.release_en_o), 32'h0);

        // Fill all slots with d=63.
        for (int i = 0; i < 8; i++) begin
            req(1'b1, 4'(i), 6'd63);
            cyc(1);
        end
        req(1'b0, 4'd0, 6'd0);
        check("t3_full_ready", 32'(bus.req_ready_o), 32'h0);
        cyc(55);
        check("t3_before_expiry", 32'(bus.req_ready_o), 32'h0);
        cyc(1);
        check("t3_slot_freed", 32'(bus.req_ready_o), 32'h1);
        check("t3_first_release", 32'(bus.release_en_o), 32'h0001);
        cyc(7);
        check("t3_all_release", 32'(bus.release_en_o), 32'h00ff);
        drain();
        check("t3_drained", 32'(bus.release_en_o), 32'h0);

        // Outstanding bound on the MaxOutstanding=4 instance.
        for (int i = 0; i < 4; i++) begin
            bus4.req_valid_i = 1'b1;
            bus4.req_id_i    = 4'd0;
            bus4.req_delay_i = 6'd1;
            cyc(1);
            if (i == 2) check("t4_ready_at_3", 32'(bus4.req_ready_o), 32'h1);
        end
        bus4.req_valid_i = 1'b0;
        check("t4_bound_ready", 32'(bus4.req_ready_o), 32'h0);
        check("t4_release", 32'(bus4.release_en_o), 32'h0001);
        bus4.rsp_done_i = 1'b1;
        bus4.rsp_id_i   = 4'd0;
        cyc(1);
        bus4.rsp_done_i = 1'b0;
        check("t4_ready_after_done", 32'(bus4.req_ready_o), 32'h1);
        bus4.rsp_done_i = 1'b1;
        cyc(3);
        bus4.rsp_done_i = 1'b0;
        check("t4_drained", 32'(bus4.release_en_o), 32'h0);

        // Async reset with slots counting and credit[5]=2.
        req(1'b1, 4'd5, 6'd1);
        cyc(1);
        req(1'b1, 4'd5, 6'd1);
        cyc(1);
        for (int i = 1; i <= 3; i++) begin
            req(1'b1, 4'(i), 6'd40);
            cyc(1);
        end
        req(1'b0, 4'd0, 6'd0);
        check("t6_pre_reset", 32'(bus.release_en_o), 32'h0020);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_reset_release", 32'(bus.release_en_o), 32'h0);
        check("t6_reset_ready", 32'(bus.req_ready_o), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        req(1'b1, 4'd5, 6'd4);
        cyc(1);
        req(1'b0, 4'd0, 6'd0);
        cyc(3);
        check("t6_before_rise", 32'(bus.release_en_o), 32'h0);
        cyc(1);
        check("t6_rise", 32'(bus.release_en_o), 32'h0020);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
